ex_muldiv_seq: RTL and testbench

Multi-cycle 16-bit unsigned multiply/divide unit for the EX stage. It takes the MULT (CTRL=1) and DIV (CTRL=2) operations out of the combinational ALU path. Operands are captured on a start handshake, iterated one bit per clock, and results are returned with a one-cycle done pulse. Result/remainder/overflow semantics match the ALU's MULT/DIV outputs, so the EX mux can select either source.

---
 rtl/ex_muldiv_seq_if.sv | 24 ++
 rtl/ex_muldiv_seq.sv | 137 +++++++++++++
 tb/tb_ex_muldiv_seq.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_seq_if.sv
// Handshake and result bundle between the EX stage and the sequential multiply/divide unit.
interface ex_muldiv_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [3:0]       CTRL;
    logic [WIDTH-1:0] MUX_intop;
    logic [WIDTH-1:0] MUX_inbottom;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] ALU_Result;
    logic [WIDTH-1:0] Remainder;
    logic             Overflow_flag;

    modport master (
        output start, CTRL, MUX_intop, MUX_inbottom,
        input  busy, done, ALU_Result, Remainder, Overflow_flag
    );

    modport slave (
        input  start, CTRL, MUX_intop, MUX_inbottom,
        output busy, done, ALU_Result, Remainder, Overflow_flag
    );
endinterface

// File: rtl/ex_muldiv_seq.sv
// Multi-cycle unsigned multiply (shift-add) / divide (restoring), one bit per clock.
//   state  | meaning
//   IDLE   | waiting for start; outputs hold last result
//   RUN    | iterating, WIDTH steps
//   DONE   | results valid, done pulse, back to IDLE
module ex_muldiv_seq #(
    parameter int         WIDTH   = 16,
    parameter logic [3:0] OP_MULT = 4'd1,
    parameter logic [3:0] OP_DIV  = 4'd2
) (
    input  logic            clk,
    input  logic            rst,
    ex_muldiv_seq_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               is_div_q, is_div_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               ovf_q, ovf_d;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_neg;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] step;

    // Shared accumulator: MULT keeps the multiplier in the low half and shifts the
    // partial product in from the top; DIV keeps remainder high, dividend/quotient low.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        div_neg   = div_diff[WIDTH];
        div_rem   = div_neg ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
        div_next  = {div_rem, acc_q[WIDTH-2:0], ~div_neg};
        step      = is_div_q ? div_next : mul_next;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        is_div_d = is_div_q;
        res_d    = res_q;
        rem_d    = rem_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.CTRL == OP_MULT) begin
                        acc_d    = {{WIDTH{1'b0}}, bus.MUX_inbottom};
                        opb_d    = bus.MUX_intop;
                        is_div_d = 1'b0;
                        cnt_d    = CW'(WIDTH - 1);
                        state_d  = S_RUN;
                    end else if (bus.CTRL == OP_DIV) begin
                        if (bus.MUX_inbottom != '0) begin
                            acc_d    = {{WIDTH{1'b0}}, bus.MUX_intop};
                            opb_d    = bus.MUX_inbottom;
                            is_div_d = 1'b1;
                            cnt_d    = CW'(WIDTH - 1);
                            state_d  = S_RUN;
                        end else begin
                            // Divide by zero resolves immediately with ALU-compatible values.
                            res_d   = '1;
                            rem_d   = bus.MUX_intop;
                            ovf_d   = 1'b1;
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_RUN: begin
                acc_d = step;
                if (cnt_q == '0) begin
                    res_d   = step[WIDTH-1:0];
                    rem_d   = step[2*WIDTH-1:WIDTH];
                    ovf_d   = is_div_q ? 1'b0 : (|step[2*WIDTH-1:WIDTH]);
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            is_div_q <= 1'b0;
            res_q    <= '0;
            rem_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            is_div_q <= is_div_d;
            res_q    <= res_d;
            rem_q    <= rem_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.busy          = (state_q != S_IDLE);
    assign bus.done          = (state_q == S_DONE);
    assign bus.ALU_Result    = res_q;
    assign bus.Remainder     = rem_q;
    assign bus.Overflow_flag = ovf_q;
endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed bench for the sequential multiply/divide unit with hand-computed expectations.
module tb_ex_muldiv_seq;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ex_muldiv_seq_if #(.WIDTH(16)) bus ();

    ex_muldiv_seq #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one request at a negedge; returns at the negedge where done is seen
    // (or after a 100-clock budget). lat counts posedges from the accepting edge.
    task automatic do_op(input logic [3:0] ctrl, input logic [15:0] a, input logic [15:0] b,
                         output int lat, output int busy_cnt);
        @(negedge clk);
        bus.start = 1'b1; bus.CTRL = ctrl; bus.MUX_intop = a; bus.MUX_inbottom = b;
        @(posedge clk);
        lat = 1; busy_cnt = 0;
        @(negedge clk);
        bus.start = 1'b0;
        while (1) begin
            if (bus.busy) busy_cnt++;
            if (bus.done || lat >= 100) break;
            @(posedge clk); lat++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.CTRL = 4'd0; bus.MUX_intop = '0; bus.MUX_inbottom = '0;
        repeat (3) @(negedge clk);
        checks++; if (bus.ALU_Result !== 16'h0) begin errors++; $display("FAIL reset_result: got %h want 0000", bus.ALU_Result); end
        checks++; if (bus.Remainder !== 16'h0) begin errors++; $display("FAIL reset_rem: got %h want 0000", bus.Remainder); end
        checks++; if (bus.Overflow_flag !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", bus.Overflow_flag); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mult();
        int lat, bc;
        do_op(4'd1, 16'd1000, 16'd50, lat, bc);
        checks++; if (lat !== 17) begin errors++; $display("FAIL mult_latency: got %0d want 17", lat); end
        checks++; if (bc !== 17) begin errors++; $display("FAIL mult_busy_cycles: got %0d want 17", bc); end
        checks++; if (bus.ALU_Result !== 16'hC350) begin errors++; $display("FAIL mult_result: got %h want c350", bus.ALU_Result); end
        checks++; if (bus.Remainder !== 16'h0) begin errors++; $display("FAIL mult_hi: got %h want 0000", bus.Remainder); end
        checks++; if (bus.Overflow_flag !== 1'b0) begin errors++; $display("FAIL mult_ovf: got %b want 0", bus.Overflow_flag); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL mult_pulse_end: done %b busy %b want 0 0", bus.done, bus.busy); end
        checks++; if (bus.ALU_Result !== 16'hC350) begin errors++; $display("FAIL mult_hold: got %h want c350", bus.ALU_Result); end
    endtask

    task automatic test_mult_overflow();
        int lat, bc;
        do_op(4'd1, 16'd300, 16'd300, lat, bc);
        checks++; if (lat !== 17) begin errors++; $display("FAIL ovf_latency: got %0d want 17", lat); end
        checks++; if (bus.ALU_Result !== 16'h5F90) begin errors++; $display("FAIL ovf_result: got %h want 5f90", bus.ALU_Result); end
        checks++; if (bus.Remainder !== 16'h0001) begin errors++; $display("FAIL ovf_hi: got %h want 0001", bus.Remainder); end
        checks++; if (bus.Overflow_flag !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", bus.Overflow_flag); end
        do_op(4'd1, 16'hFFFF, 16'hFFFF, lat, bc);
        checks++; if (bus.ALU_Result !== 16'h0001) begin errors++; $display("FAIL max_mult_lo: got %h want 0001", bus.ALU_Result); end
        checks++; if (bus.Remainder !== 16'hFFFE) begin errors++; $display("FAIL max_mult_hi: got %h want fffe", bus.Remainder); end
        checks++; if (bus.Overflow_flag !== 1'b1) begin errors++; $display("FAIL max_mult_ovf: got %b want 1", bus.Overflow_flag); end
    endtask

    task automatic test_div_back_to_back();
        int lat, bc;
        do_op(4'd2, 16'd1003, 16'd50, lat, bc);
        checks++; if (lat !== 17) begin errors++; $display("FAIL div_latency: got %0d want 17", lat); end
        checks++; if (bus.ALU_Result !== 16'd20) begin errors++; $display("FAIL div_quot: got %0d want 20", bus.ALU_Result); end
        checks++; if (bus.Remainder !== 16'd3) begin errors++; $display("FAIL div_rem: got %0d want 3", bus.Remainder); end
        checks++; if (bus.Overflow_flag !== 1'b0) begin errors++; $display("FAIL div_ovf: got %b want 0", bus.Overflow_flag); end
        // do_op asserts start on the next negedge: the cycle right after done
        do_op(4'd2, 16'd1000, 16'd50, lat, bc);
        checks++; if (lat !== 17) begin errors++; $display("FAIL b2b_latency: got %0d want 17", lat); end
        checks++; if (bus.ALU_Result !== 16'd20) begin errors++; $display("FAIL b2b_quot: got %0d want 20", bus.ALU_Result); end
        checks++; if (bus.Remainder !== 16'd0) begin errors++; $display("FAIL b2b_rem: got %0d want 0", bus.Remainder); end
        do_op(4'd2, 16'hFFFF, 16'd7, lat, bc);
        checks++; if (bus.ALU_Result !== 16'd9362 || bus.Remainder !== 16'd1) begin errors++; $display("FAIL div_big: got %0d r %0d want 9362 r 1", bus.ALU_Result, bus.Remainder); end
    endtask

    task automatic test_div_zero();
        int lat, bc;
        do_op(4'd2, 16'd1000, 16'd0, lat, bc);
        checks++; if (lat !== 1) begin errors++; $display("FAIL dz_latency: got %0d want 1", lat); end
        checks++; if (bus.ALU_Result !== 16'hFFFF) begin errors++; $display("FAIL dz_result: got %h want ffff", bus.ALU_Result); end
        checks++; if (bus.Remainder !== 16'd1000) begin errors++; $display("FAIL dz_rem: got %0d want 1000", bus.Remainder); end
        checks++; if (bus.Overflow_flag !== 1'b1) begin errors++; $display("FAIL dz_ovf: got %b want 1", bus.Overflow_flag); end
    endtask

    task automatic test_ignored();
        int saw_busy, saw_done, lat;
        saw_busy = 0; saw_done = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.CTRL = 4'd15; bus.MUX_intop = 16'd5; bus.MUX_inbottom = 16'd6;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.busy) saw_busy++;
            if (bus.done) saw_done++;
            @(negedge clk);
        end
        checks++; if (saw_busy !== 0 || saw_done !== 0) begin errors++; $display("FAIL bad_ctrl: busy %0d done %0d want 0 0", saw_busy, saw_done); end
        checks++; if (bus.ALU_Result !== 16'hFFFF || bus.Remainder !== 16'd1000 || bus.Overflow_flag !== 1'b1)
            begin errors++; $display("FAIL bad_ctrl_hold: got %h %0d %b want ffff 1000 1", bus.ALU_Result, bus.Remainder, bus.Overflow_flag); end
        // Restart attempt and operand changes mid-RUN must not disturb the op in flight.
        bus.start = 1'b1; bus.CTRL = 4'd1; bus.MUX_intop = 16'd1000; bus.MUX_inbottom = 16'd50;
        @(posedge clk); lat = 1;
        @(negedge clk); bus.start = 1'b0;
        while (!bus.done && lat < 100) begin
            if (lat == 5) begin bus.start = 1'b1; bus.CTRL = 4'd2; bus.MUX_intop = 16'd7; bus.MUX_inbottom = 16'd3; end
            if (lat == 7) bus.start = 1'b0;
            @(posedge clk); lat++;
            @(negedge clk);
        end
        checks++; if (lat !== 17) begin errors++; $display("FAIL restart_latency: got %0d want 17", lat); end
        checks++; if (bus.ALU_Result !== 16'hC350 || bus.Remainder !== 16'h0 || bus.Overflow_flag !== 1'b0)
            begin errors++; $display("FAIL restart_result: got %h %h %b want c350 0000 0", bus.ALU_Result, bus.Remainder, bus.Overflow_flag); end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL restart_no_queue: busy %b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid_op();
        int saw_done, lat, bc;
        saw_done = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.CTRL = 4'd1; bus.MUX_intop = 16'd1000; bus.MUX_inbottom = 16'd50;
        @(posedge clk);
        @(negedge clk); bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.ALU_Result !== 16'h0 || bus.Remainder !== 16'h0 || bus.Overflow_flag !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0)
            begin errors++; $display("FAIL async_reset: got %h %h %b busy %b done %b want all 0", bus.ALU_Result, bus.Remainder, bus.Overflow_flag, bus.busy, bus.done); end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus.done || bus.busy) saw_done++;
            @(negedge clk);
        end
        checks++; if (saw_done !== 0) begin errors++; $display("FAIL abort_no_done: saw %0d active cycles want 0", saw_done); end
        do_op(4'd1, 16'd1000, 16'd50, lat, bc);
        checks++; if (lat !== 17 || bus.ALU_Result !== 16'hC350) begin errors++; $display("FAIL post_reset_op: lat %0d result %h want 17 c350", lat, bus.ALU_Result); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mult();
        test_mult_overflow();
        test_div_back_to_back();
        test_div_zero();
        test_ignored();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
